// File: rtl/weight_tile_gen.sv
// weight_tile_gen: walks an nT x nT block tile by tile, emitting angular or planar blend weights
// with a single registered valid/ready output stage.
module weight_tile_gen #(
    parameter int TILE     = 4,
    parameter int WW       = 8,
    parameter int MAX_LOG2 = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      angle_or_planar,
    input  logic [2:0]                log2_size,
    output logic                      busy,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [TILE*TILE*5-1:0]    frac_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TILE*TILE*WW-1:0]   weight1,
    output logic [TILE*TILE*WW-1:0]   weight2,
    output logic [MAX_LOG2-1:0]       tile_x,
    output logic [MAX_LOG2-1:0]       tile_y,
    output logic                      last,
    output logic                      done
);
    localparam int LT = $clog2(TILE);
    localparam int NP = TILE * TILE;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state_q, state_d;
    logic                  ang_q, ang_d;
    logic [2:0]            l_q, l_d, lsz_c;
    logic [MAX_LOG2-1:0]   tx_q, tx_d, ty_q, ty_d, ntm1;
    logic                  out_valid_q, last_q, tx_end, at_end, adv, load;
    logic [MAX_LOG2-1:0]   tile_x_q, tile_y_q;
    logic [NP*WW-1:0]      w1_q, w2_q, w1_d, w2_d;

    assign lsz_c  = log2_size > 3'(MAX_LOG2) ? 3'(MAX_LOG2)
                  : (log2_size < 3'(LT) ? 3'(LT) : log2_size);
    assign ntm1   = MAX_LOG2'((32'd1 << (l_q - 3'(LT))) - 32'd1);
    assign tx_end = tx_q == ntm1;
    assign at_end = tx_end & (ty_q == ntm1);
    assign adv    = (state_q == RUN) & (!out_valid_q | out_ready);
    assign load   = adv & (!ang_q | in_valid);

    assign in_ready  = adv & ang_q;
    assign busy      = state_q != IDLE;
    assign done      = (state_q == DRAIN) & out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    assign last      = last_q;
    assign tile_x    = tile_x_q;
    assign tile_y    = tile_y_q;
    assign weight1   = w1_q;
    assign weight2   = w2_q;

    // Planar weights come from the origin of the tile being loaded (tx_q/ty_q), not the held one.
    for (genvar i = 0; i < NP; i++) begin : g_w
        logic [4:0] f;
        assign f = frac_in[i*5 +: 5];
        assign w1_d[i*WW +: WW] = ang_q ? WW'(f) : WW'(int'(tx_q) * TILE + i % TILE + 1);
        assign w2_d[i*WW +: WW] = ang_q ? WW'(6'd32 - {1'b0, f}) : WW'(int'(ty_q) * TILE + i / TILE + 1);
    end

    always_comb begin
        state_d = state_q;
        ang_d   = ang_q;
        l_d     = l_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        if (state_q == IDLE && start) begin
            state_d = RUN;
            ang_d   = angle_or_planar;
            l_d     = lsz_c;
            tx_d    = '0;
            ty_d    = '0;
        end
        if (load) begin
            tx_d    = tx_end ? '0 : tx_q + 1'b1;
            ty_d    = tx_end ? ty_q + 1'b1 : ty_q;
            state_d = at_end ? DRAIN : state_q;
        end
        if (done)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ang_q       <= 1'b0;
            l_q         <= '0;
            tx_q        <= '0;
            ty_q        <= '0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            tile_x_q    <= '0;
            tile_y_q    <= '0;
            w1_q        <= '0;
            w2_q        <= '0;
        end else begin
            state_q     <= state_d;
            ang_q       <= ang_d;
            l_q         <= l_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            out_valid_q <= load | (out_valid_q & !out_ready);
            if (load) begin
                last_q   <= at_end;
                tile_x_q <= MAX_LOG2'(int'(tx_q) * TILE);
                tile_y_q <= MAX_LOG2'(int'(ty_q) * TILE);
                w1_q     <= w1_d;
                w2_q     <= w2_d;
            end
        end
    end
endmodule

// File: tb/tb_weight_tile_gen.sv
// tb_weight_tile_gen: scoreboard bench; stimulus queues expected tiles, a negedge monitor checks them.
module tb_weight_tile_gen;
    logic         clk = 0, rst_n = 0, start = 0, ang = 0, in_valid = 0, out_ready = 1;
    logic [2:0]   lsz = '0;
    logic [79:0]  frac_in = '0;
    logic         busy, in_ready, out_valid, last, done;
    logic [127:0] w1, w2;
    logic [4:0]   tx, ty;

    always #5 clk = ~clk;

    weight_tile_gen #(.TILE(4), .WW(8), .MAX_LOG2(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .angle_or_planar(ang), .log2_size(lsz),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .frac_in(frac_in),
        .out_valid(out_valid), .out_ready(out_ready), .weight1(w1), .weight2(w2),
        .tile_x(tx), .tile_y(ty), .last(last), .done(done)
    );

    typedef struct {logic [4:0] x, y; logic lst; logic [127:0] a, b;} exp_t;

    exp_t         q[$];
    exp_t         me, snap;
    int           checks = 0, errors = 0, n_pop = 0;
    logic [4:0]   lx, ly;
    logic [127:0] lw1, lw2;
    bit           cur_ang = 0, stall_q = 0;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic check_zero(input string n);
        chk({n, "_valid"}, 128'(out_valid), 0);
        chk({n, "_last"}, 128'(last), 0);
        chk({n, "_done"}, 128'(done), 0);
        chk({n, "_in_ready"}, 128'(in_ready), 0);
        chk({n, "_busy"}, 128'(busy), 0);
        chk({n, "_tile_x"}, 128'(tx), 0);
        chk({n, "_tile_y"}, 128'(ty), 0);
        chk({n, "_w1"}, w1, 0);
        chk({n, "_w2"}, w2, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_q) begin
                chk("stall_valid", 128'(out_valid), 1);
                chk("stall_x", 128'(tx), 128'(snap.x));
                chk("stall_y", 128'(ty), 128'(snap.y));
                chk("stall_last", 128'(last), 128'(snap.lst));
                chk("stall_w1", w1, snap.a);
                chk("stall_w2", w2, snap.b);
            end
            if (out_valid && !out_ready) chk("in_ready_stall", 128'(in_ready), 0);
            if (busy && !cur_ang) chk("in_ready_planar", 128'(in_ready), 0);
            if (done) chk("done_needs_hs", 128'(out_valid && out_ready), 1);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got tile (%0d,%0d) expected none", tx, ty);
                end else begin
                    me = q.pop_front();
                    chk("tile_x", 128'(tx), 128'(me.x));
                    chk("tile_y", 128'(ty), 128'(me.y));
                    chk("last", 128'(last), 128'(me.lst));
                    chk("done", 128'(done), 128'(me.lst));
                    chk("weight1", w1, me.a);
                    chk("weight2", w2, me.b);
                    n_pop++;
                    lx = tx; ly = ty; lw1 = w1; lw2 = w2;
                end
            end
            stall_q = out_valid && !out_ready;
            snap = '{tx, ty, last, w1, w2};
        end else
            stall_q = 0;
    end

    // a: angular, ls: log2_size driven, L: effective log2, rmode: 0 always ready / 1 pattern 1,0,0,1,
    // hold: extra cycles start stays high, gap: idle cycles between angular beats,
    // fsel: fraction pattern, abort: cycle at which reset hits mid-block (0 = never)
    task automatic run_block(input bit a, input logic [2:0] ls, input int L, input int rmode,
                             input int hold, input int gap, input int fsel, input int abort);
        int          nt, n, bi, gc, f;
        logic [79:0] fr[64];
        exp_t        e;
        bit          fin, aborted;
        nt = 1 << (L - 2);
        n  = nt * nt;
        for (int b = 0; b < n; b++) begin
            e.x   = 5'((b % nt) * 4);
            e.y   = 5'((b / nt) * 4);
            e.lst = (b == n - 1);
            for (int p = 0; p < 16; p++) begin
                f = (fsel == 0) ? ((p == 15) ? 0 : 5) : (b * 7 + p) % 32;
                fr[b][p*5 +: 5] = 5'(f);
                e.a[p*8 +: 8] = a ? 8'(f) : 8'(int'(e.x) + p % 4 + 1);
                e.b[p*8 +: 8] = a ? 8'(32 - f) : 8'(int'(e.y) + p / 4 + 1);
            end
            q.push_back(e);
        end
        cur_ang = a; n_pop = 0; bi = 0; gc = 0; fin = 0; aborted = 0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(posedge clk); #1;
            start     = (cyc <= hold);
            ang       = a;
            lsz       = ls;
            out_ready = (rmode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = a && bi < n && gc >= gap;
            frac_in   = (bi < n) ? fr[bi] : '0;
            @(negedge clk);
            if (!a && cyc == 1) chk("latency_c1", 128'(out_valid), 0);
            if (!a && cyc == 2) chk("latency_c2", 128'(out_valid), 1);
            if (in_valid && in_ready) begin
                bi++;
                gc = 0;
            end else if (!in_valid) gc++;
            fin = done;
            if (abort > 0 && cyc == abort) begin
                #1 rst_n = 0;
                #1 check_zero("midreset");
                q.delete();
                aborted = 1;
                break;
            end
        end
        start = 0; in_valid = 0; out_ready = 1;
        if (aborted) begin
            repeat (2) @(posedge clk);
            #1 rst_n = 1;
            return;
        end
        chk("done_seen", 128'(fin), 1);
        @(posedge clk); #1;
        chk("busy_after", 128'(busy), 0);
        chk("beats", 128'(n_pop), 128'(n));
        chk("sb_empty", 128'(q.size()), 0);
    endtask

    initial begin
        #12 check_zero("reset");
        @(posedge clk); #1 rst_n = 1;

        run_block(0, 3'd3, 3, 0, 0, 0, 0, 0);
        chk("p3_last_x", 128'(lx), 4);
        chk("p3_last_y", 128'(ly), 4);
        chk("p3_w1_r0c3", 128'(lw1[24 +: 8]), 8);
        chk("p3_w2_r3c0", 128'(lw2[96 +: 8]), 8);

        run_block(1, 3'd2, 2, 0, 0, 0, 0, 0);
        chk("a2_w1_p0", 128'(lw1[0 +: 8]), 5);
        chk("a2_w2_p0", 128'(lw2[0 +: 8]), 27);
        chk("a2_w1_p15", 128'(lw1[120 +: 8]), 0);
        chk("a2_w2_p15", 128'(lw2[120 +: 8]), 32);

        run_block(0, 3'd4, 4, 1, 0, 0, 0, 0);
        run_block(1, 3'd3, 3, 1, 0, 3, 1, 0);

        run_block(0, 3'd1, 2, 0, 0, 0, 0, 0);
        chk("clamp_lo_x", 128'(lx), 0);
        chk("clamp_lo_w1_r0c3", 128'(lw1[24 +: 8]), 4);

        run_block(0, 3'd7, 5, 0, 0, 0, 0, 0);
        chk("clamp_hi_x", 128'(lx), 28);
        chk("clamp_hi_y", 128'(ly), 28);
        chk("clamp_hi_w1", 128'(lw1[24 +: 8]), 32);
        chk("clamp_hi_w2", 128'(lw2[96 +: 8]), 32);

        run_block(0, 3'd3, 3, 0, 4, 0, 0, 0);
        run_block(0, 3'd5, 5, 0, 0, 0, 0, 9);
        run_block(0, 3'd3, 3, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
